// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS datapath: HI/LO multiplier state encoding
// and default operand width.
package mips_pkg;

    localparam int MULT_DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CALC   = 2'd1,
        FINISH = 2'd2
    } mult_state_t;

endpackage

// File: rtl/mult_step.sv
// One shift-add iteration: adds multiplicand times the low STEP accumulator bits
// into the upper field, then shifts the whole accumulator right by STEP.
module mult_step
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_DEFAULT_WIDTH,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]          mcand,
    input  logic [2*WIDTH+STEP-1:0]   acc_in,
    output logic [2*WIDTH+STEP-1:0]   acc_out
);

    localparam int ACC_W = 2 * WIDTH + STEP;
    localparam int UPR_W = WIDTH + STEP;

    logic [UPR_W-1:0] upper;
    logic [UPR_W-1:0] partial;
    logic [UPR_W-1:0] sum;
    logic [WIDTH-1:0] lower;
    logic [STEP-1:0]  digit;

    assign upper = acc_in[ACC_W-1 -: UPR_W];
    assign lower = acc_in[WIDTH-1:0];
    assign digit = acc_in[STEP-1:0];

    // NOTE: blocking assignments here: each loop pass must see the running partial sum.
    always_comb begin
        partial = '0;
        for (int i = 0; i < STEP; i++) begin
            if (digit[i]) begin
                partial = partial + (UPR_W'(mcand) << i);
            end
        end
    end

    // upper stays below 2^WIDTH after every shift, so this add cannot overflow UPR_W.
    assign sum     = upper + partial;
    assign acc_out = {sum, lower} >> STEP;

endmodule

// File: rtl/iterative_multiplier.sv
// Multi-cycle signed/unsigned shift-add multiplier for the HI/LO unit; produces
// the full 2*WIDTH-bit product with a start/done handshake.
module iterative_multiplier
    import mips_pkg::*;
#(
    parameter int WIDTH = MULT_DEFAULT_WIDTH,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int N     = WIDTH / STEP;
    localparam int CNT_W = $clog2(N + 1);
    localparam int ACC_W = 2 * WIDTH + STEP;

    if ((WIDTH % STEP) != 0 || WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_params
        $error("iterative_multiplier: WIDTH must be even, >= 4, and divisible by STEP");
    end

    mult_state_t         state;
    mult_state_t         next_state;
    logic [WIDTH-1:0]    mcand;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_next;
    logic [CNT_W-1:0]    cnt;
    logic                neg;
    logic                last_iter;
    logic [WIDTH-1:0]    a_mag;
    logic [WIDTH-1:0]    b_mag;
    logic [2*WIDTH-1:0]  product;
    logic [2*WIDTH-1:0]  result;

    // |-2^(WIDTH-1)| wraps to 2^(WIDTH-1), which is exactly right read as unsigned.
    assign a_mag = (signed_op && a[WIDTH-1]) ? -a : a;
    assign b_mag = (signed_op && b[WIDTH-1]) ? -b : b;

    assign last_iter = (cnt == CNT_W'(N - 1));
    assign product   = acc[2*WIDTH-1:0];
    assign result    = neg ? -product : product;

    mult_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .mcand   (mcand),
        .acc_in  (acc),
        .acc_out (acc_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (last_iter) next_state = FINISH;
            FINISH:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            done <= (state == FINISH);
            unique case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= a_mag;
                        acc   <= {{(WIDTH + STEP){1'b0}}, b_mag};
                        cnt   <= '0;
                        neg   <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                end
                FINISH: begin
                    {hi, lo} <= result;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_iterative_multiplier.sv
// Self-checking bench: vector table and random ops against a 64-bit reference,
// handshake/reset corner sequences, and the STEP=4 and WIDTH=8 variants.
module tb_iterative_multiplier;
    import mips_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic        start0 = 1'b0, s0 = 1'b0, busy0, done0;
    logic [31:0] a0 = '0, b0 = '0, hi0, lo0;
    logic        start1 = 1'b0, s1 = 1'b0, busy1, done1;
    logic [31:0] a1 = '0, b1 = '0, hi1, lo1;
    logic        start2 = 1'b0, s2 = 1'b0, busy2, done2;
    logic [7:0]  a2 = '0, b2 = '0, hi2, lo2;

    int total = 0;
    int bad   = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        s;
        logic [63:0] p;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    iterative_multiplier #(.WIDTH(32), .STEP(1)) d0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .signed_op(s0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .hi(hi0), .lo(lo0));

    iterative_multiplier #(.WIDTH(32), .STEP(4)) d1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .signed_op(s1), .a(a1), .b(b1),
        .busy(busy1), .done(done1), .hi(hi1), .lo(lo1));

    iterative_multiplier #(.WIDTH(8), .STEP(2)) d2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .signed_op(s2), .a(a2), .b(b2),
        .busy(busy2), .done(done2), .hi(hi2), .lo(lo2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input int which, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic st);
        case (which)
            0: begin start0 = st; a0 = a; b0 = b; s0 = s; end
            1: begin start1 = st; a1 = a; b1 = b; s1 = s; end
            default: begin start2 = st; a2 = a[7:0]; b2 = b[7:0]; s2 = s; end
        endcase
    endtask

    function automatic logic dn(input int which);
        case (which)
            0: return done0;
            1: return done1;
            default: return done2;
        endcase
    endfunction

    function automatic logic [63:0] prod(input int which);
        case (which)
            0: return {hi0, lo0};
            1: return {hi1, lo1};
            default: return {48'b0, hi2, lo2};
        endcase
    endfunction

    function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint p;
        if (s) p = longint'($signed(a)) * longint'($signed(b));
        else   p = longint'({32'b0, a}) * longint'({32'b0, b});
        return 64'(p);
    endfunction

    function automatic logic [63:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
        int pa;
        int pb;
        int p;
        logic [15:0] r;
        pa = s ? int'($signed(a)) : int'(a);
        pb = s ? int'($signed(b)) : int'(b);
        p  = pa * pb;
        r  = 16'(p);
        return {48'b0, r};
    endfunction

    task automatic pop_check(input int which, input string name);
        logic [63:0] exp;
        if (sb.size() == 0) begin
            check({name, " scoreboard empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check({name, " product"}, prod(which), exp);
        end
    endtask

    // Counts edges from the accepting edge until done is seen, bounded.
    task automatic wait_done(input int which, input int exp_lat, input string name);
        int cyc = 0;
        while (!dn(which) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, " latency"}, 64'(cyc), 64'(exp_lat));
        pop_check(which, name);
    endtask

    task automatic run_op(input int which, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [63:0] exp, input int lat, input string name);
        sb.push_back(exp);
        drive(which, a, b, s, 1'b1);
        @(posedge clk); #1;
        drive(which, a, b, s, 1'b0);
        wait_done(which, lat, name);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        logic [7:0]  corners[5];
        int          cyc;
        int          changes;
        int          pulses;

        vecs[0]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001};
        vecs[1]  = '{32'hFFFFFFFD, 32'h00000005, 1'b1, 64'hFFFFFFFF_FFFFFFF1};
        vecs[2]  = '{32'hFFFFFFFD, 32'h00000005, 1'b0, 64'h00000004_FFFFFFF1};
        vecs[3]  = '{32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000};
        vecs[4]  = '{32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000};
        vecs[5]  = '{32'h00000000, 32'h12345678, 1'b1, 64'h00000000_00000000};
        vecs[6]  = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 64'h00000000_00000001};
        vecs[7]  = '{32'h7FFFFFFF, 32'h7FFFFFFF, 1'b1, 64'h3FFFFFFF_00000001};
        vecs[8]  = '{32'h80000000, 32'h7FFFFFFF, 1'b1, 64'hC0000000_80000000};
        vecs[9]  = '{32'h80000000, 32'h80000000, 1'b0, 64'h40000000_00000000};
        vecs[10] = '{32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000};
        vecs[11] = '{32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFF_FFFFFFFE};
        corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};

        repeat (3) @(posedge clk);
        #1;
        check("reset busy", 64'(busy0), 64'd0);
        check("reset done", 64'(done0), 64'd0);
        check("reset hilo", {hi0, lo0}, 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Consecutive ops start in the previous op's done cycle (back-to-back).
        for (int i = 0; i < 12; i++) begin
            run_op(0, vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].p, 33, $sformatf("vec%0d", i));
        end

        for (int i = 0; i < 16; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            run_op(0, ra, rb, rs, model32(ra, rb, rs), 33, $sformatf("rand%0d", i));
        end

        // Mid-CALC start must be ignored.
        sb.push_back(64'd42);
        drive(0, 32'd7, 32'd6, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 32'd7, 32'd6, 1'b0, 1'b0);
        cyc = 0;
        repeat (5) begin @(posedge clk); #1; cyc++; end
        check("busy mid calc", 64'(busy0), 64'd1);
        drive(0, 32'd2, 32'd2, 1'b0, 1'b1);
        @(posedge clk); #1; cyc++;
        drive(0, 32'd2, 32'd2, 1'b0, 1'b0);
        while (!done0 && cyc < 200) begin @(posedge clk); #1; cyc++; end
        check("ignored start latency", 64'(cyc), 64'd33);
        pop_check(0, "ignored start");

        // Start in the done cycle; result must hold 42 until the new FINISH.
        sb.push_back(64'd4);
        drive(0, 32'd2, 32'd2, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 32'd2, 32'd2, 1'b0, 1'b0);
        check("done single pulse", 64'(done0), 64'd0);
        check("busy after b2b start", 64'(busy0), 64'd1);
        cyc = 0;
        changes = 0;
        while (!done0 && cyc < 200) begin
            if ({hi0, lo0} !== 64'd42) changes++;
            @(posedge clk); #1;
            cyc++;
        end
        check("hilo held during op", 64'(changes), 64'd0);
        check("b2b latency", 64'(cyc), 64'd33);
        pop_check(0, "b2b");

        // Reset after 10 CALC iterations.
        drive(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1);
        @(posedge clk); #1;
        drive(0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
        repeat (10) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("abort busy", 64'(busy0), 64'd0);
        check("abort hilo", {hi0, lo0}, 64'd0);
        check("abort done", 64'(done0), 64'd0);
        check("abort state", 64'(d0.state), 64'(IDLE));
        rst_n = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done0) pulses++;
        end
        check("abort no done", 64'(pulses), 64'd0);

        run_op(1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 9, "s4 umax");
        run_op(1, 32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF_80000000, 9, "s4 minx1");
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rs = 1'($urandom_range(0, 1));
            run_op(1, ra, rb, rs, model32(ra, rb, rs), 9, $sformatf("s4 rand%0d", i));
        end

        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                for (int m = 0; m < 2; m++) begin
                    run_op(2, {24'b0, corners[i]}, {24'b0, corners[j]}, 1'(m),
                           model8(corners[i], corners[j], 1'(m)), 5,
                           $sformatf("w8 corner %0d_%0d_%0d", i, j, m));
                end
            end
        end
        for (int i = 0; i < 1500; i++) begin
            ra = {24'b0, 8'($urandom)};
            rb = {24'b0, 8'($urandom)};
            rs = 1'($urandom_range(0, 1));
            run_op(2, ra, rb, rs, model8(ra[7:0], rb[7:0], rs), 5, $sformatf("w8 rand%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
